switch_conditioner: RTL and testbench

- Conditions raw board switch and button inputs before they enter the SoC wrapper.
- Feeds `fetch_en` (switch 7) and `gpio_i` (switches 0-3) into `croc_soc`.
- Per-channel pipeline: multi-flop synchroniser, counter-based debouncer, one-cycle edge pulses.
- Runs in the `soc_clk` domain, directly upstream of the SoC fetch-enable and GPIO input muxing.

---
 rtl/switch_conditioner.sv | 71 +++++++
 tb/tb_switch_conditioner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronise, debounce and edge-detect raw board switch inputs
module switch_conditioner #(
    parameter int unsigned                 NumInputs      = 4,
    parameter int unsigned                 SyncStages     = 2,
    parameter int unsigned                 DebounceCycles = 200000,
    parameter logic [NumInputs-1:0]        ResetValue     = '0
) (
    input  logic                 soc_clk,
    input  logic                 rst_n,
    input  logic [NumInputs-1:0] raw_i,
    output logic [NumInputs-1:0] clean_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o,
    output logic                 stable_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [SyncStages-1:0][NumInputs-1:0] sync_q, sync_d;
    logic [NumInputs-1:0][CntW-1:0]       cnt_q, cnt_d;
    logic [NumInputs-1:0]                 clean_q, clean_d;
    logic [NumInputs-1:0]                 rise_q, rise_d;
    logic [NumInputs-1:0]                 fall_q, fall_d;
    logic                                 stable_q, stable_d;
    logic [NumInputs-1:0]                 sync, diff, acc;

    assign sync = sync_q[SyncStages-1];
    assign diff = sync ^ clean_q;

    // Shift raw levels through the synchroniser; accept a level once it has disagreed long enough
    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], raw_i};
        acc     = '0;
        cnt_d   = '0;
        for (int i = 0; i < NumInputs; i++) begin
            acc[i]   = diff[i] && (cnt_q[i] == CntMax);
            cnt_d[i] = (diff[i] && !acc[i]) ? cnt_q[i] + CntOne : '0;
        end
        clean_d  = clean_q ^ acc;
        rise_d   = acc & sync;
        fall_d   = acc & ~sync;
        stable_d = (cnt_d == '0);
    end

    // State registers; reset is asynchronous, release arrives already synchronised
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SyncStages{ResetValue}};
            cnt_q    <= '0;
            clean_q  <= ResetValue;
            rise_q   <= '0;
            fall_q   <= '0;
            stable_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stable_q <= stable_d;
        end
    end

    assign clean_o  = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign stable_o = stable_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed scoreboard bench for switch_conditioner (DebounceCycles 4 and 1)
module tb_switch_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw, raw1;
    logic [3:0] clean, rise, fall, clean1, rise1, fall1;
    logic       stable, stable1;

    always #5 clk = ~clk;

    switch_conditioner #(.NumInputs(4), .SyncStages(2), .DebounceCycles(4), .ResetValue(4'h0)) dut (
        .soc_clk(clk), .rst_n(rst_n), .raw_i(raw),
        .clean_o(clean), .rise_o(rise), .fall_o(fall), .stable_o(stable)
    );

    switch_conditioner #(.NumInputs(4), .SyncStages(2), .DebounceCycles(1), .ResetValue(4'h0)) dut1 (
        .soc_clk(clk), .rst_n(rst_n), .raw_i(raw1),
        .clean_o(clean1), .rise_o(rise1), .fall_o(fall1), .stable_o(stable1)
    );

    typedef struct {
        int         c;
        bit         d1;
        logic [3:0] cl;
        logic [3:0] ri;
        logic [3:0] fa;
        logic       st;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit d1, input logic [3:0] cl, input logic [3:0] ri,
                        input logic [3:0] fa, input logic st, input string tag);
        exp_t e;
        e.c = c; e.d1 = d1; e.cl = cl; e.ri = ri; e.fa = fa; e.st = st; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input string f, input int c, input logic [3:0] got, input logic [3:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s cyc %0d: observed %h expected %h", tag, f, c, got, want);
        end
    endtask

    // Pop every expectation due this cycle and compare against the selected DUT
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_assert++;
            assert (e.c == cyc) else begin
                n_fail++;
                $error("FAIL %s.sched: observed cycle %0d expected cycle %0d", e.tag, cyc, e.c);
            end
            if (e.c == cyc) begin
                chk(e.tag, "clean", cyc, e.d1 ? clean1 : clean, e.cl);
                chk(e.tag, "rise", cyc, e.d1 ? rise1 : rise, e.ri);
                chk(e.tag, "fall", cyc, e.d1 ? fall1 : fall, e.fa);
                chk(e.tag, "stable", cyc, {3'b000, e.d1 ? stable1 : stable}, {3'b000, e.st});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() > 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d pending expectations, expected 0", q.size());
        end
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         n, m;
        logic [8:0] pat;
        logic [12:0] bst;
        logic [15:0] cl1;
        pat = 9'b111101101;
        bst = 13'b1100010010111;
        cl1 = 16'h20F8;
        rst_n = 1'b0;
        raw = 4'hF;
        raw1 = 4'h0;
        push(1, 0, 4'h0, 4'h0, 4'h0, 1'b1, "rst_hold");
        push(1, 1, 4'h0, 4'h0, 4'h0, 1'b1, "rst_hold1");
        push(2, 0, 4'h0, 4'h0, 4'h0, 1'b1, "rst_hold");
        tick(2);
        m = cyc;
        for (int k = 1; k <= 7; k++)
            push(m + k, 0, (k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0,
                 (k >= 3 && k <= 5) ? 1'b0 : 1'b1, "release");
        rst_n = 1'b1;
        drain();

        n = cyc;
        for (int k = 1; k <= 7; k++)
            push(n + k, 0, (k >= 6) ? 4'h3 : 4'hF, 4'h0, (k == 6) ? 4'hC : 4'h0,
                 (k >= 3 && k <= 5) ? 1'b0 : 1'b1, "fall_indep");
        raw = 4'h3;
        drain();

        n = cyc;
        for (int k = 1; k <= 7; k++)
            push(n + k, 0, (k >= 6) ? 4'h0 : 4'h3, 4'h0, (k == 6) ? 4'h3 : 4'h0,
                 (k >= 3 && k <= 5) ? 1'b0 : 1'b1, "fall_low");
        raw = 4'h0;
        drain();

        n = cyc;
        for (int k = 1; k <= 10; k++)
            push(n + k, 0, 4'h0, 4'h0, 4'h0, (k >= 3 && k <= 5) ? 1'b0 : 1'b1, "glitch");
        raw = 4'h1;
        tick(3);
        raw = 4'h0;
        drain();

        n = cyc;
        for (int k = 1; k <= 12; k++)
            push(n + k, 0, (k >= 11) ? 4'h2 : 4'h0, (k == 11) ? 4'h2 : 4'h0, 4'h0, bst[k], "bounce");
        for (int j = 0; j <= 8; j++) begin
            raw = {2'b00, pat[j], 1'b0};
            tick(1);
        end
        drain();

        n = cyc;
        push(n + 3, 0, 4'h2, 4'h0, 4'h0, 1'b0, "mid_count");
        push(n + 5, 0, 4'h0, 4'h0, 4'h0, 1'b1, "mid_reset");
        raw = 4'h3;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_async", "clean", cyc, clean, 4'h0);
        tick(2);
        m = cyc;
        for (int k = 1; k <= 7; k++)
            push(m + k, 0, (k >= 6) ? 4'h3 : 4'h0, (k == 6) ? 4'h3 : 4'h0, 4'h0,
                 (k >= 3 && k <= 5) ? 1'b0 : 1'b1, "mid_release");
        rst_n = 1'b1;
        drain();

        n = cyc;
        for (int k = 2; k <= 15; k++)
            push(n + k, 1, {3'b000, cl1[k]}, {3'b000, cl1[k] & ~cl1[k-1]},
                 {3'b000, ~cl1[k] & cl1[k-1]}, 1'b1, "deb1");
        raw1 = 4'h1;
        tick(5);
        raw1 = 4'h0;
        tick(5);
        raw1 = 4'h1;
        tick(1);
        raw1 = 4'h0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
